// File: rtl/ahb_master_arbiter.sv
// Round-robin arbiter sharing one AHB master port between two requesters.
// Issues one single-beat 32-bit NONSEQ transfer per grant, with a wait-state timeout.
module ahb_master_arbiter #(
    parameter logic [3:0] HPROT   = 4'd1,
    parameter logic [7:0] TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic        write0,
    input  logic        write1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    output logic [1:0]  gnt,
    output logic        ack,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] haddr,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    input  logic [31:0] hrdata,
    output logic        hready_in,
    input  logic        hready_out,
    input  logic        hresp,
    output logic [2:0]  hsize,
    output logic [1:0]  htrans,
    output logic [31:0] hwdata,
    output logic        hwrite,
    output logic        sel
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic        prio1_q, prio1_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic [1:0]  gnt_q, gnt_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] haddr_q, haddr_d;
    logic [2:0]  hburst_q, hburst_d;
    logic [3:0]  hprot_q, hprot_d;
    logic        hready_in_q, hready_in_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        hwrite_q, hwrite_d;
    logic        sel_q, sel_d;

    logic        pick1;
    logic        wait_cycle;

    always_comb begin
        state_d     = state_q;
        prio1_d     = prio1_q;
        wcnt_d      = wcnt_q;
        gnt_d       = gnt_q;
        ack_d       = ack_q;
        err_d       = err_q;
        rdata_d     = rdata_q;
        haddr_d     = haddr_q;
        hburst_d    = '0;
        hprot_d     = hprot_q;
        hready_in_d = hready_in_q;
        hsize_d     = hsize_q;
        htrans_d    = htrans_q;
        hwdata_d    = hwdata_q;
        hwrite_d    = hwrite_q;
        sel_d       = sel_q;
        pick1       = 1'b0;
        wait_cycle  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (hready_out && (req0 || req1)) begin
                    // prio1_q set means requester 0 won last, so requester 1 takes a tie
                    pick1       = req1 && (!req0 || prio1_q);
                    prio1_d     = !pick1;
                    gnt_d       = pick1 ? 2'b10 : 2'b01;
                    haddr_d     = pick1 ? addr1 : addr0;
                    hwrite_d    = pick1 ? write1 : write0;
                    hwdata_d    = pick1 ? wdata1 : wdata0;
                    htrans_d    = 2'b10;
                    hsize_d     = 3'b010;
                    hprot_d     = HPROT;
                    sel_d       = 1'b1;
                    hready_in_d = 1'b1;
                    wcnt_d      = '0;
                    state_d     = ADDR;
                end
            end
            ADDR: begin
                if (hready_out) begin
                    htrans_d = '0;
                    state_d  = DATA;
                end else begin
                    wait_cycle = 1'b1;
                end
            end
            DATA: begin
                if (hready_out) begin
                    if (!hwrite_q) begin
                        rdata_d = hrdata;
                    end
                    err_d    = hresp;
                    sel_d    = 1'b0;
                    hprot_d  = '0;
                    hwrite_d = 1'b0;
                    hwdata_d = '0;
                    haddr_d  = '0;
                    hsize_d  = '0;
                    ack_d    = 1'b1;
                    state_d  = DONE;
                end else begin
                    wait_cycle = 1'b1;
                end
            end
            DONE: begin
                ack_d       = 1'b0;
                err_d       = 1'b0;
                gnt_d       = '0;
                hready_in_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Abort on the wait cycle that brings the count to TIMEOUT, so it never wraps
        if (wait_cycle) begin
            wcnt_d = wcnt_q + 8'd1;
            if (wcnt_d == TIMEOUT) begin
                haddr_d     = '0;
                hprot_d     = '0;
                hready_in_d = 1'b0;
                hsize_d     = '0;
                htrans_d    = '0;
                hwdata_d    = '0;
                hwrite_d    = 1'b0;
                sel_d       = 1'b0;
                err_d       = 1'b1;
                ack_d       = 1'b1;
                state_d     = DONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            prio1_q     <= 1'b0;
            wcnt_q      <= '0;
            gnt_q       <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            haddr_q     <= '0;
            hburst_q    <= '0;
            hprot_q     <= '0;
            hready_in_q <= 1'b0;
            hsize_q     <= '0;
            htrans_q    <= '0;
            hwdata_q    <= '0;
            hwrite_q    <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prio1_q     <= prio1_d;
            wcnt_q      <= wcnt_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            haddr_q     <= haddr_d;
            hburst_q    <= hburst_d;
            hprot_q     <= hprot_d;
            hready_in_q <= hready_in_d;
            hsize_q     <= hsize_d;
            htrans_q    <= htrans_d;
            hwdata_q    <= hwdata_d;
            hwrite_q    <= hwrite_d;
            sel_q       <= sel_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign haddr     = haddr_q;
    assign hburst    = hburst_q;
    assign hprot     = hprot_q;
    assign hready_in = hready_in_q;
    assign hsize     = hsize_q;
    assign htrans    = htrans_q;
    assign hwdata    = hwdata_q;
    assign hwrite    = hwrite_q;
    assign sel       = sel_q;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed plus randomized bench for ahb_master_arbiter against a transaction-level timeline model.
module tb_ahb_master_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic        write0, write1;
    logic [31:0] wdata0, wdata1;
    logic [1:0]  gnt;
    logic        ack, err;
    logic [31:0] rdata, haddr;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic [31:0] hrdata;
    logic        hready_in, hready_out, hresp;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [31:0] hwdata;
    logic        hwrite, sel;

    ahb_master_arbiter #(.HPROT(4'd1), .TIMEOUT(8'd255)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
        .write0(write0), .write1(write1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt(gnt), .ack(ack), .err(err), .rdata(rdata),
        .haddr(haddr), .hburst(hburst), .hprot(hprot), .hrdata(hrdata),
        .hready_in(hready_in), .hready_out(hready_out), .hresp(hresp),
        .hsize(hsize), .htrans(htrans), .hwdata(hwdata), .hwrite(hwrite), .sel(sel)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          checks = 0;
    int          errors = 0;
    int          last_win = 1;
    logic [31:0] exp_rdata = '0;
    int unsigned ack_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bus_idle(input string tag);
        check({tag, " haddr"}, haddr, 32'h0);
        check({tag, " htrans"}, {30'b0, htrans}, 32'h0);
        check({tag, " hsize"}, {29'b0, hsize}, 32'h0);
        check({tag, " hprot"}, {28'b0, hprot}, 32'h0);
        check({tag, " hwdata"}, hwdata, 32'h0);
        check({tag, " hwrite"}, {31'b0, hwrite}, 32'h0);
        check({tag, " sel"}, {31'b0, sel}, 32'h0);
        check({tag, " hburst"}, {29'b0, hburst}, 32'h0);
    endtask

    // One transaction from IDLE: aw/dw are address/data-phase wait states the slave inserts.
    task automatic xfer(input bit r0, input bit r1, input int unsigned aw, input int unsigned dw,
                        input bit resp, input logic [31:0] rd);
        int          win;
        logic [31:0] ea, ewd;
        logic        ew;
        bit          to;
        int unsigned ack_k;

        win = (r0 && r1) ? 1 - last_win : (r0 ? 0 : 1);
        last_win = win;
        ea  = win ? addr1 : addr0;
        ewd = win ? wdata1 : wdata0;
        ew  = win ? write1 : write0;
        to  = (aw + dw) >= 255;
        ack_k = !to ? aw + dw + 2 : (aw >= 255 ? 255 : 256);

        req0 = r0; req1 = r1; hready_out = 1'b1; hresp = resp; hrdata = rd;
        @(posedge clk); #1;
        check("grant gnt", {30'b0, gnt}, win ? 32'd2 : 32'd1);
        check("grant htrans", {30'b0, htrans}, 32'd2);
        check("grant haddr", haddr, ea);
        check("grant hsize", {29'b0, hsize}, 32'd2);
        check("grant sel", {31'b0, sel}, 32'd1);
        check("grant hwrite", {31'b0, hwrite}, {31'b0, ew});
        check("grant hwdata", hwdata, ewd);
        check("grant hprot", {28'b0, hprot}, 32'd1);
        check("grant hready_in", {31'b0, hready_in}, 32'd1);
        check("grant ack", {31'b0, ack}, 32'd0);

        // Inputs changing after the grant must not reach the bus
        addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
        write0 = 1'($urandom); write1 = 1'($urandom);

        for (int unsigned k = 1; k <= ack_k; k++) begin
            hready_out = (k == aw + 1) || (k > aw + 1 + dw);
            @(posedge clk); #1;
            if (k < ack_k) begin
                check("wait ack", {31'b0, ack}, 32'd0);
                check("wait haddr", haddr, ea);
                check("wait hwdata", hwdata, ewd);
                check("wait hwrite", {31'b0, hwrite}, {31'b0, ew});
                check("wait htrans", {30'b0, htrans}, (k <= aw) ? 32'd2 : 32'd0);
                check("wait gnt", {30'b0, gnt}, win ? 32'd2 : 32'd1);
            end
        end

        ack_cyc = cyc;
        if (!to && !ew) exp_rdata = rd;
        check("done ack", {31'b0, ack}, 32'd1);
        check("done err", {31'b0, err}, to ? 32'd1 : {31'b0, resp});
        check("done gnt", {30'b0, gnt}, win ? 32'd2 : 32'd1);
        check("done rdata", rdata, exp_rdata);
        check("done hready_in", {31'b0, hready_in}, to ? 32'd0 : 32'd1);
        check_bus_idle("done");

        hready_out = 1'b1;
        @(posedge clk); #1;
        check("idle ack", {31'b0, ack}, 32'd0);
        check("idle err", {31'b0, err}, 32'd0);
        check("idle gnt", {30'b0, gnt}, 32'd0);
        check("idle hready_in", {31'b0, hready_in}, 32'd0);
    endtask

    initial begin
        int unsigned prev;

        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        addr0 = '0; addr1 = '0; write0 = 1'b0; write1 = 1'b0; wdata0 = '0; wdata1 = '0;
        hrdata = '0; hready_out = 1'b1; hresp = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset gnt", {30'b0, gnt}, 32'd0);
        check("reset ack", {31'b0, ack}, 32'd0);
        check("reset err", {31'b0, err}, 32'd0);
        check("reset rdata", rdata, 32'd0);
        check("reset hready_in", {31'b0, hready_in}, 32'd0);
        check_bus_idle("reset");
        reset = 1'b1;

        // Read, no wait states
        addr0 = 32'h5000_0000; write0 = 1'b0;
        xfer(1, 0, 0, 0, 0, 32'h0102_0304);
        check("read rdata", rdata, 32'h0102_0304);
        req0 = 1'b0;

        // Write, 3 data-phase wait states
        addr1 = 32'h5000_0004; wdata1 = 32'h0403_0201; write1 = 1'b1;
        xfer(0, 1, 0, 3, 0, 32'hdead_beef);
        req1 = 1'b0;

        // Simultaneous requests: alternate, one transfer every 4 cycles
        addr0 = 32'h1000_0000; addr1 = 32'h2000_0000; write0 = 1'b0; write1 = 1'b1;
        xfer(1, 1, 0, 0, 0, 32'h1111_1111);
        prev = ack_cyc;
        for (int i = 0; i < 3; i++) begin
            xfer(1, 1, 0, 0, 0, 32'h2222_0000 + 32'(i));
            check("b2b spacing", ack_cyc - prev, 32'd4);
            prev = ack_cyc;
        end
        req0 = 1'b0; req1 = 1'b0;

        // Slave error, then a normal transfer
        addr0 = 32'h3000_0000; write0 = 1'b0;
        xfer(1, 0, 0, 1, 1, 32'hcafe_0001);
        req0 = 1'b0;
        addr1 = 32'h3000_0010; write1 = 1'b0;
        xfer(0, 1, 1, 0, 0, 32'hcafe_0002);
        req1 = 1'b0;

        // Timeouts: hung in address phase, then hung in data phase
        addr0 = 32'h4000_0000; write0 = 1'b0;
        xfer(1, 0, 300, 0, 0, 32'h7777_7777);
        req0 = 1'b0;
        addr1 = 32'h4000_0004; write1 = 1'b1; wdata1 = 32'h8888_8888;
        xfer(0, 1, 10, 300, 0, 32'h9999_9999);
        req1 = 1'b0;

        // No arbitration while the slave is not ready; a dropped request is never served
        req0 = 1'b1; hready_out = 1'b0;
        @(posedge clk); #1;
        check("blocked gnt", {30'b0, gnt}, 32'd0);
        check("blocked htrans", {30'b0, htrans}, 32'd0);
        req0 = 1'b0; hready_out = 1'b1;
        @(posedge clk); #1;
        check("dropped gnt", {30'b0, gnt}, 32'd0);

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            int sel_req;
            sel_req = int'($urandom_range(1, 3));
            addr0 = $urandom; addr1 = $urandom; wdata0 = $urandom; wdata1 = $urandom;
            write0 = 1'($urandom); write1 = 1'($urandom);
            xfer(sel_req[0], sel_req[1], $urandom_range(0, 3), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), $urandom);
            req0 = 1'b0; req1 = 1'b0;
        end

        // Reset during the data phase; requester 0 was granted last before the reset
        addr0 = 32'h5000_0100; write0 = 1'b0; req0 = 1'b1; req1 = 1'b0; hready_out = 1'b1; hresp = 1'b0;
        @(posedge clk); #1;
        check("pre-reset gnt", {30'b0, gnt}, 32'd1);
        @(posedge clk); #1;
        hready_out = 1'b0;
        @(posedge clk); #1;
        check("pre-reset ack", {31'b0, ack}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midreset gnt", {30'b0, gnt}, 32'd0);
        check("midreset ack", {31'b0, ack}, 32'd0);
        check("midreset err", {31'b0, err}, 32'd0);
        check("midreset rdata", rdata, 32'd0);
        check("midreset hready_in", {31'b0, hready_in}, 32'd0);
        check_bus_idle("midreset");
        reset = 1'b1;
        last_win = 1;
        exp_rdata = '0;
        addr0 = 32'h6000_0000; addr1 = 32'h6000_0004; write0 = 1'b0; write1 = 1'b0;
        xfer(1, 1, 0, 0, 0, 32'h0a0b_0c0d);
        req0 = 1'b0; req1 = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
